axis_pkt_fifo: RTL
==================

Name: axis_pkt_fifo

Overview:
- Single-clock AXI-Stream FIFO with packet framing. Buffers a free-running sample stream, such as capture data, and cuts it into fixed-length packets by generating master_tlast.
- A flush request closes a partial packet early.
- Generalises the earlier capture FIFO with a power-of-two depth and a true full flag (extra pointer bit), so all DEPTH entries are usable.
- Adds programmable packet length, flush support, and an optional occupancy/almost-full status port.

Parameters:
- DATAW, 32: data width in bits, 1 or more.
- DEPTH, 512: FIFO entries; must be a power of two and at least 4.
- PKTLEN, 256: beats per packet, 1 or more; master_tlast is asserted on the PKTLEN-th beat of each packet.
- AFULL_THRESH, DEPTH-4: level at or above which almost_full is asserted (optional feature only).

Ports:
- slave_clk  in  1  single clock for both sides.
- reset  in  1  synchronous, active-high.
- slave_tdata  in  DATAW  input beat.
- slave_tvalid  in  1  input valid.
- slave_tready  out  1  high when the FIFO is not full.
- master_tdata  out  DATAW  output beat.
- master_tvalid  out  1  high when the FIFO is not empty.
- master_tlast  out  1  end of packet.
- master_tready  in  1  downstream ready.
- flush  in  1  single-cycle pulse that closes the current packet at the last buffered beat.
- level  out  $clog2(DEPTH)+1  occupancy (AXIS_PKT_FIFO_LEVEL_EN only).
- almost_full  out  1  level >= AFULL_THRESH (AXIS_PKT_FIFO_LEVEL_EN only).

Behaviour:
- Clocking and reset:
  - reset: reset, synchronous, active-high; clock: slave_clk.
  - Everything is sampled on the rising edge of slave_clk.
- Reset values:
  - wr_ptr, rd_ptr, beat_cnt and flush_pend are 0.
  - Outputs: slave_tready=1, master_tvalid=0, master_tlast=0, level=0, almost_full=0.
  - Memory contents are not reset.
  - Reset mid-packet discards all buffered data and any pending flush; beat_cnt restarts at 0.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; the low bits address the RAM.
  - Both wrap naturally modulo 2*DEPTH.
  - Empty when wr_ptr == rd_ptr.
  - Full when the low bits are equal and the MSBs differ.
  - level = wr_ptr - rd_ptr, truncated to the pointer width; it ranges 0..DEPTH.
- Write handshake:
  - A write occurs when slave_tvalid && slave_tready.
  - slave_tdata is stored at wr_ptr and wr_ptr increments.
  - slave_tready is derived combinationally as !full.
- Read handshake:
  - master_tvalid = !empty; master_tdata = mem[rd_ptr] (first-word fall-through).
  - A read occurs when master_tvalid && master_tready, and rd_ptr increments.
- Latency:
  - A beat written in cycle N is visible on master_tvalid/master_tdata in cycle N+1.
  - There is no same-cycle pass-through when the FIFO is empty.
- Simultaneous read and write:
  - Allowed at any level except empty (no read possible) and full (no write possible).
  - Level is unchanged.
  - At full, a read in the same cycle does not enable a write; slave_tready stays low for that cycle.
- Packet counter:
  - beat_cnt, width $clog2(PKTLEN+1), counts accepted output beats in the current packet.
- master_tlast:
  - Asserted combinationally when master_tvalid && (beat_cnt == PKTLEN-1 || (flush_pend && level == 1)).
  - On a read with master_tlast=1, beat_cnt is set to 0 and flush_pend is cleared.
  - On a read with master_tlast=0, beat_cnt is incremented.
- Flush:
  - A flush pulse sets flush_pend only if the FIFO is non-empty, or a write occurs in the same cycle.
  - A flush on an empty, idle FIFO is ignored.
  - Writes arriving after a flush extend the packet: tlast lands on whichever beat is last in the FIFO when it is read.
  - If beat_cnt reaches PKTLEN-1 first, that tlast also clears flush_pend.
  - A flush while flush_pend is already set has no additional effect.
- PKTLEN=1: every beat has tlast=1.
- Data stability: master_tdata, master_tvalid and master_tlast are held while master_tvalid && !master_tready.

Optional Feature:
- Macro: AXIS_PKT_FIFO_LEVEL_EN.
- When defined:
  - The level and almost_full ports exist.
  - almost_full is registered: updated each cycle from the next-state level, so it matches level in the same cycle. It resets to 0.
- When undefined:
  - Both ports and their logic are absent; the rest of the behaviour is identical.

Test Plan (DATAW=8, DEPTH=8, PKTLEN=4, AFULL_THRESH=6):
- Fill and drain: write 0x01..0x0A with master_tready=0.
  - slave_tready drops after the 8th write; level=8 and almost_full=1 from level 6.
  - Then master_tready=1: output is 0x01..0x08 in order, with tlast on 0x04 and 0x08.
- Latency and wrap: stream 20 beats with tready=1 on both sides.
  - Each beat appears one cycle after its write.
  - Pointers wrap and data is intact.
  - tlast on beats 4, 8, 12, 16, 20.
- Flush partial: write 0x11, 0x22, 0x33, pulse flush, then drain.
  - tlast on 0x33.
  - Next packet: 4 new beats give tlast on the 4th.
- Flush extended: write 0x11, pulse flush, write 0x22 before any read, then drain.
  - tlast only on 0x22; flush_pend is 0 afterwards.
- Full boundary: fill to 8, then hold slave_tvalid=1 and master_tready=1 for one cycle.
  - One read, no write; level=7 next cycle, and a write is accepted the cycle after.
- Reset mid-packet: write 3 beats, read 2, assert reset for 1 cycle.
  - master_tvalid=0 and level=0.
  - The next 4 beats written produce tlast on the 4th; an empty-FIFO flush pulse causes no tlast.

Source files
------------

// File: rtl/axis_pkt_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_fifo_if
// Description : AXI-Stream handshake bundle for axis_pkt_fifo. It carries the
//               slave (input) side, the master (output) side and the flush
//               request. The "slave" modport is the FIFO's view. The "master"
//               modport is the view of the surrounding logic that feeds and
//               drains the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_pkt_fifo_if #(
  parameter int DATAW = 32
);
  logic [DATAW-1:0] slave_tdata;
  logic             slave_tvalid;
  logic             slave_tready;
  logic [DATAW-1:0] master_tdata;
  logic             master_tvalid;
  logic             master_tlast;
  logic             master_tready;
  logic             flush;

  modport slave (
    input  slave_tdata, slave_tvalid, master_tready, flush,
    output slave_tready, master_tdata, master_tvalid, master_tlast
  );

  modport master (
    output slave_tdata, slave_tvalid, master_tready, flush,
    input  slave_tready, master_tdata, master_tvalid, master_tlast
  );
endinterface
`default_nettype wire

// File: rtl/axis_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_fifo
// Description : Single-clock first-word-fall-through AXI-Stream FIFO. It cuts
//               a free-running stream into PKTLEN-beat packets by generating
//               master_tlast. A flush pulse closes a partial packet at the
//               last buffered beat. Depth is a power of two, and an extra
//               pointer bit gives a true full flag.
//               Optional macro AXIS_PKT_FIFO_LEVEL_EN adds the level and
//               almost_full status ports.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_fifo #(
  parameter int DATAW        = 32,
  parameter int DEPTH        = 512,
  parameter int PKTLEN       = 256,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                   slave_clk,
  input  logic                   reset,
  axis_pkt_fifo_if.slave         bus
`ifdef AXIS_PKT_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(PKTLEN + 1);
  localparam logic [CW-1:0] c_last_cnt = CW'(PKTLEN - 1);
  localparam logic [PW-1:0] c_one      = PW'(1);

  // Reject configurations the pointer arithmetic cannot support.
  generate
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (PKTLEN < 1) ||
        (DATAW < 1) || (AFULL_THRESH > DEPTH)) begin : g_param_check
      $error("axis_pkt_fifo: illegal parameter set");
    end
  endgenerate

  logic [DATAW-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_beat_cnt;
  logic             r_flush_pend;

  logic             w_empty;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;
  logic [PW-1:0]    w_level;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;

  // The extra MSB tells a full FIFO apart from an empty one when the RAM addresses match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_level = r_wr_ptr - r_rd_ptr;

  assign bus.slave_tready  = !w_full;
  assign bus.master_tvalid = !w_empty;
  assign bus.master_tdata  = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.master_tlast  = !w_empty &&
                             ((r_beat_cnt == c_last_cnt) ||
                              (r_flush_pend && (w_level == c_one)));

  assign w_wr = bus.slave_tvalid && !w_full;
  assign w_rd = !w_empty && bus.master_tready;

  assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd);

  // Storage RAM. Contents are not reset; the pointers alone define validity.
  always_ff @(posedge slave_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.slave_tdata;
    end
  end

  // Read and write pointers wrap naturally modulo 2*DEPTH.
  always_ff @(posedge slave_clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // Beat counter: a read that carries tlast restarts the packet.
  always_ff @(posedge slave_clk) begin
    if (reset) begin
      r_beat_cnt <= '0;
    end else if (w_rd) begin
      if (bus.master_tlast) begin
        r_beat_cnt <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + CW'(1);
      end
    end
  end

  // Flush pending: armed only if a beat exists or is arriving. Any tlast read
  // disarms it. A new flush request takes priority over that disarm.
  always_ff @(posedge slave_clk) begin
    if (reset) begin
      r_flush_pend <= 1'b0;
    end else if (bus.flush && (!w_empty || w_wr)) begin
      r_flush_pend <= 1'b1;
    end else if (w_rd && bus.master_tlast) begin
      r_flush_pend <= 1'b0;
    end
  end

`ifdef AXIS_PKT_FIFO_LEVEL_EN
  localparam logic [PW-1:0] c_afull_thresh = PW'(AFULL_THRESH);

  logic [PW-1:0] w_level_nxt;
  logic          r_almost_full;

  assign w_level_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
  assign level       = w_level;
  assign almost_full = r_almost_full;

  // almost_full is computed from the next-state level so it tracks level with no lag.
  always_ff @(posedge slave_clk) begin
    if (reset) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_level_nxt >= c_afull_thresh);
    end
  end
`endif

endmodule
`default_nettype wire
